// File: rtl/directory_request_sequencer.sv
// rtl/directory_request_sequencer.sv - serialises P0/P1 coherence requests onto the MSI directory and memory
//
// Purpose: round-robin arbitrates between two L1 request ports, looks up the
// directory entry, recalls/invalidates other sharers, fetches read data from
// memory, writes the directory entry back and returns a response. One
// transaction is in flight at a time.
//
// Ports:
//   Clock, Reset                 clock, synchronous active-high reset
//   ReqValid/ReqWrite[1:0]       per-port request level and op (1 = write)
//   ReqAddr0/1, ReqData0/1       per-port address and write data
//   ReqReady[1:0]                one-hot accept pulse (IDLE only)
//   RespValid[1:0], RespData     one-hot completion pulse and its data
//   DirAddr, DirState, DirSharers       combinational directory read
//   DirUpdate, DirNewState, DirNewSharers  directory write strobe and data
//   InvValid[1:0], InvAck[1:0]   invalidate/recall handshake per cache
//   MemRead, MemAddr, MemRData, MemDone    memory read handshake
//   Busy, Error                  not idle; sticky timeout/illegal-state flag
module directory_request_sequencer #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 4,
  parameter int INV_TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [1:0]        ReqValid,
  input  logic [1:0]        ReqWrite,
  input  logic [ADDR_W-1:0] ReqAddr0,
  input  logic [ADDR_W-1:0] ReqAddr1,
  input  logic [DATA_W-1:0] ReqData0,
  input  logic [DATA_W-1:0] ReqData1,
  output logic [1:0]        ReqReady,
  output logic [1:0]        RespValid,
  output logic [DATA_W-1:0] RespData,
  output logic [ADDR_W-1:0] DirAddr,
  input  logic [2:0]        DirState,
  input  logic [1:0]        DirSharers,
  output logic              DirUpdate,
  output logic [2:0]        DirNewState,
  output logic [1:0]        DirNewSharers,
  output logic [1:0]        InvValid,
  input  logic [1:0]        InvAck,
  output logic              MemRead,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [DATA_W-1:0] MemRData,
  input  logic              MemDone,
  output logic              Busy,
  output logic              Error
);

  localparam int CNT_W = $clog2(INV_TIMEOUT + 2);
  localparam logic [2:0] ST_S = 3'b010;
  localparam logic [2:0] ST_M = 3'b011;

  typedef enum logic [2:0] {IDLE, LOOKUP, INVAL, MEMRD, UPDATE, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;      // 1 = P1 was granted last
  logic                gid_q, gid_d;        // granted requester
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   mdata_q, mdata_d;
  logic [1:0]          pend_q, pend_d;      // invalidations still awaiting ack
  logic [1:0]          recall_q, recall_d;  // every cache invalidated this transaction
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic                gnt;
  logic                need_inv;
  logic [1:0]          gbit;
  logic [1:0]          others;

  assign gbit   = gid_q ? 2'b10 : 2'b01;
  assign others = DirSharers & ~gbit;
  assign Busy   = (state_q != IDLE);
  assign Error  = err_q;

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    gid_d         = gid_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    mdata_d       = mdata_q;
    pend_d        = pend_q;
    recall_d      = recall_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    gnt           = 1'b0;
    need_inv      = 1'b0;
    ReqReady      = 2'b00;
    RespValid     = 2'b00;
    RespData      = '0;
    DirAddr       = '0;
    DirUpdate     = 1'b0;
    DirNewState   = 3'b000;
    DirNewSharers = 2'b00;
    InvValid      = 2'b00;
    MemRead       = 1'b0;
    MemAddr       = '0;

    case (state_q)
      IDLE: begin
        // Grant is withheld while Reset is high so nothing is accepted on the reset edge.
        if (ReqValid != 2'b00 && !Reset) begin
          gnt      = (ReqValid == 2'b11) ? ~last_q : ReqValid[1];
          ReqReady = gnt ? 2'b10 : 2'b01;
          last_d   = gnt;
          gid_d    = gnt;
          wr_d     = ReqWrite[gnt];
          addr_d   = gnt ? ReqAddr1 : ReqAddr0;
          wdata_d  = gnt ? ReqData1 : ReqData0;
          mdata_d  = '0;
          recall_d = 2'b00;
          pend_d   = 2'b00;
          cnt_d    = '0;
          state_d  = LOOKUP;
        end
      end

      LOOKUP: begin
        DirAddr = addr_q;
        // Encodings 1xx are illegal: flag them and fall through as Invalid.
        if (DirState[2]) err_d = 1'b1;
        if (wr_q) need_inv = (others != 2'b00);
        else      need_inv = (DirState == ST_M) && (others != 2'b00);
        if (need_inv) begin
          pend_d   = others;
          recall_d = others;
          cnt_d    = '0;
          state_d  = INVAL;
        end else begin
          state_d  = wr_q ? UPDATE : MEMRD;
        end
      end

      INVAL: begin
        InvValid = pend_q;
        pend_d   = pend_q & ~InvAck;
        if (pend_d == 2'b00) begin
          state_d = wr_q ? UPDATE : MEMRD;
        end else if (cnt_q == CNT_W'(INV_TIMEOUT)) begin
          // Give up on the missing acks; the directory is still rewritten.
          err_d   = 1'b1;
          pend_d  = 2'b00;
          state_d = UPDATE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end

      MEMRD: begin
        MemRead = 1'b1;
        MemAddr = addr_q;
        if (MemDone) begin
          mdata_d = MemRData;
          state_d = UPDATE;
        end
      end

      UPDATE: begin
        DirUpdate = 1'b1;
        DirAddr   = addr_q;
        if (wr_q) begin
          DirNewState   = ST_M;
          DirNewSharers = gbit;
        end else begin
          DirNewState   = ST_S;
          DirNewSharers = (DirSharers & ~recall_q) | gbit;
        end
        state_d = RESP;
      end

      RESP: begin
        RespValid = gbit;
        RespData  = wr_q ? wdata_q : mdata_q;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      gid_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mdata_q  <= '0;
      pend_q   <= 2'b00;
      recall_q <= 2'b00;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gid_q    <= gid_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mdata_q  <= mdata_d;
      pend_q   <= pend_d;
      recall_q <= recall_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_directory_request_sequencer.sv
// tb/tb_directory_request_sequencer.sv - scoreboard bench for directory_request_sequencer
module tb_directory_request_sequencer;

  localparam int INV_TIMEOUT = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rv0, rv1, rw0, rw1;
  logic [3:0] ra0, ra1, rd0, rd1;
  logic [1:0] req_valid, req_write;
  assign req_valid = {rv1, rv0};
  assign req_write = {rw1, rw0};

  logic [1:0] req_ready, resp_valid, dir_sharers, dir_new_sharers, inv_valid, inv_ack;
  logic [3:0] resp_data, dir_addr, mem_addr, mem_rdata;
  logic [2:0] dir_state, dir_new_state;
  logic       dir_update, mem_read, mem_done, busy, error;

  directory_request_sequencer #(.ADDR_W(4), .DATA_W(4), .INV_TIMEOUT(INV_TIMEOUT)) dut (
    .Clock(clk), .Reset(rst),
    .ReqValid(req_valid), .ReqWrite(req_write),
    .ReqAddr0(ra0), .ReqAddr1(ra1), .ReqData0(rd0), .ReqData1(rd1),
    .ReqReady(req_ready), .RespValid(resp_valid), .RespData(resp_data),
    .DirAddr(dir_addr), .DirState(dir_state), .DirSharers(dir_sharers),
    .DirUpdate(dir_update), .DirNewState(dir_new_state), .DirNewSharers(dir_new_sharers),
    .InvValid(inv_valid), .InvAck(inv_ack),
    .MemRead(mem_read), .MemAddr(mem_addr), .MemRData(mem_rdata), .MemDone(mem_done),
    .Busy(busy), .Error(error)
  );

  // Environment: directory list, memory and cache responders
  logic [2:0] dir_st [16];
  logic [1:0] dir_sh [16];
  logic [3:0] mem_arr [16];
  logic       dw_en = 1'b0;
  logic [3:0] dw_addr;
  logic [2:0] dw_st;
  logic [1:0] dw_sh;
  int         mem_cnt = 0, mem_lat = 0, mem_lat_max;
  int         inv_cnt [2];
  int         inv_lat [2];
  int         inv_lat_max;
  logic       mem_hold, mem_noise = 1'b0;
  logic [1:0] inv_en, inv_noise = 2'b00;

  assign dir_state   = dir_st[dir_addr];
  assign dir_sharers = dir_sh[dir_addr];
  assign mem_rdata   = mem_arr[mem_addr];
  assign mem_done    = mem_read ? (!mem_hold && mem_cnt == mem_lat) : mem_noise;
  assign inv_ack[0]  = inv_valid[0] ? (inv_en[0] && inv_cnt[0] == inv_lat[0]) : inv_noise[0];
  assign inv_ack[1]  = inv_valid[1] ? (inv_en[1] && inv_cnt[1] == inv_lat[1]) : inv_noise[1];

  always @(posedge clk) begin
    mem_noise <= 1'($urandom_range(0, 1));
    inv_noise <= 2'($urandom_range(0, 3));
    if (!mem_read) begin
      mem_cnt <= 0;
      mem_lat <= int'($urandom_range(0, mem_lat_max));
    end else mem_cnt <= mem_cnt + 1;
    for (int i = 0; i < 2; i++) begin
      if (!inv_valid[i]) begin
        inv_cnt[i] <= 0;
        inv_lat[i] <= int'($urandom_range(0, inv_lat_max));
      end else inv_cnt[i] <= inv_cnt[i] + 1;
    end
    if (dir_update) begin
      dir_st[dir_addr] <= dir_new_state;
      dir_sh[dir_addr] <= dir_new_sharers;
    end else if (dw_en) begin
      dir_st[dw_addr] <= dw_st;
      dir_sh[dw_addr] <= dw_sh;
    end
  end

  // Scoreboard and monitor
  typedef struct {
    logic       g;
    logic       w;
    logic [3:0] addr;
    logic [1:0] inval;
    logic [2:0] nst;
    logic [1:0] nsh;
    logic [3:0] rdata;
    logic       tmo;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0, n_fail = 0, cycle = 0;
  logic hang_flag = 1'b0;
  logic hang_seen = 1'b0;
  logic in_flight = 1'b0, last_g = 1'b1, model_err = 1'b0, rst_prev = 1'b0, mg;
  int   t_acc, n_i, n_m, upd_cnt, upd_cyc;
  logic [1:0] inv_mask, exp_ready, mon_gb, mon_oth, mon_sh;
  logic [2:0] mon_st;
  logic [3:0] mon_d;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cycle);
    end
  endfunction

  always @(negedge clk) begin
    cycle++;
    if (cycle > 40000) begin
      n_fail++;
      $display("FAIL global_timeout: got cycle %0d, expected below 40000", cycle);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
    if (hang_flag && !hang_seen) begin
      hang_seen = 1'b1;
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout: got no handshake, expected one within bound");
    end
    if (rst) begin
      sb.delete();
      in_flight = 1'b0;
      last_g    = 1'b1;
      model_err = 1'b0;
      rst_prev  = 1'b1;
    end else begin
      if (rst_prev) begin
        chk("rst_busy", busy, 0);
        chk("rst_memread", mem_read, 0);
        chk("rst_invvalid", inv_valid, 0);
        chk("rst_dirupdate", dir_update, 0);
        chk("rst_respvalid", resp_valid, 0);
        chk("rst_error", error, 0);
        rst_prev = 1'b0;
      end
      chk("busy", busy, in_flight);
      if (!in_flight) begin
        chk("idle_respvalid", resp_valid, 0);
        chk("idle_dirupdate", dir_update, 0);
        mg        = (req_valid == 2'b11) ? !last_g : req_valid[1];
        exp_ready = (req_valid == 2'b00) ? 2'b00 : (mg ? 2'b10 : 2'b01);
        chk("req_ready", req_ready, exp_ready);
        if (req_valid != 2'b00) begin
          mon_gb     = mg ? 2'b10 : 2'b01;
          mon_e.g    = mg;
          mon_e.w    = req_write[mg];
          mon_e.addr = mg ? ra1 : ra0;
          mon_d      = mg ? rd1 : rd0;
          mon_st     = dir_st[mon_e.addr];
          mon_sh     = dir_sh[mon_e.addr];
          mon_oth    = mon_sh & ~mon_gb;
          if (mon_e.w) mon_e.inval = mon_oth;
          else         mon_e.inval = (mon_st == 3'b011) ? mon_oth : 2'b00;
          mon_e.tmo   = (mon_e.inval & ~inv_en) != 2'b00;
          mon_e.nst   = mon_e.w ? 3'b011 : 3'b010;
          mon_e.nsh   = mon_e.w ? mon_gb : ((mon_sh & ~mon_e.inval) | mon_gb);
          mon_e.rdata = mon_e.w ? mon_d : mem_arr[mon_e.addr];
          if (mon_st[2] || mon_e.tmo) model_err = 1'b1;
          sb.push_back(mon_e);
          last_g    = mg;
          in_flight = 1'b1;
          t_acc = cycle; n_i = 0; n_m = 0; upd_cnt = 0; upd_cyc = 0; inv_mask = 2'b00;
        end
      end else begin
        chk("ready_while_busy", req_ready, 0);
        inv_mask = inv_mask | inv_valid;
        if (inv_valid != 2'b00) n_i++;
        if (mem_read) n_m++;
        if (dir_update) begin
          upd_cnt++;
          upd_cyc = cycle;
          chk("dir_addr", dir_addr, sb[0].addr);
          chk("dir_new_state", dir_new_state, sb[0].nst);
          chk("dir_new_sharers", dir_new_sharers, sb[0].nsh);
        end
        if (resp_valid != 2'b00) begin
          mon_e = sb.pop_front();
          chk("resp_valid", resp_valid, mon_e.g ? 2'b10 : 2'b01);
          if (!(mon_e.tmo && !mon_e.w)) chk("resp_data", resp_data, mon_e.rdata);
          chk("inv_mask", inv_mask, mon_e.inval);
          chk("dirupdate_count", upd_cnt, 1);
          chk("dirupdate_cycle", upd_cyc, cycle - 1);
          chk("latency", cycle - t_acc, 3 + n_i + n_m);
          if (mon_e.w) chk("write_no_memread", n_m, 0);
          if (mon_e.tmo) chk("timeout_cycles", n_i, INV_TIMEOUT + 1);
          chk("error", error, model_err);
          in_flight = 1'b0;
        end else if (cycle - t_acc > 300) begin
          n_checks++;
          n_fail++;
          $display("FAIL stuck_transaction: got no RespValid after %0d cycles, expected completion", cycle - t_acc);
          sb.delete();
          in_flight = 1'b0;
        end
      end
    end
  end

  // Stimulus
  task automatic set_dir(input logic [3:0] a, input logic [2:0] st, input logic [1:0] sh);
    dw_addr = a; dw_st = st; dw_sh = sh; dw_en = 1'b1;
    @(posedge clk); #1;
    dw_en = 1'b0;
  endtask

  task automatic drive_one(input int p, input logic w, input logic [3:0] a, input logic [3:0] d);
    bit ok = 1'b0;
    if (p == 0) begin rw0 = w; ra0 = a; rd0 = d; rv0 = 1'b1; end
    else        begin rw1 = w; ra1 = a; rd1 = d; rv1 = 1'b1; end
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (req_ready[p]) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (p == 0) rv0 = 1'b0; else rv1 = 1'b0;
    if (!ok) hang_flag = 1'b1;
  endtask

  task automatic drive_port(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
      drive_one(p, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 8)), 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) hang_flag = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rv0 = 1'b0; rv1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
    ra0 = 4'h0; ra1 = 4'h0; rd0 = 4'h0; rd1 = 4'h0;
    mem_lat_max = 0; inv_lat_max = 2; mem_hold = 1'b0; inv_en = 2'b11;
    for (int i = 0; i < 16; i++) mem_arr[i] = 4'($urandom_range(0, 15));
    mem_arr[1] = 4'h1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++)
      set_dir(4'(i), 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    set_dir(4'h1, 3'b001, 2'b00);
    rst = 1'b0;

    // Read of an Invalid block, memory answers in the first MEMRD cycle
    drive_one(0, 1'b0, 4'h1, 4'h0);
    wait_idle();

    // Ties: P0 first after reset, then P1, then P0 on the next tie
    do_reset();
    mem_lat_max = 2;
    for (int r = 0; r < 2; r++) begin
      fork
        drive_one(0, 1'b0, 4'h2, 4'h3);
        drive_one(1, 1'b1, 4'h8, 4'h6);
      join
      wait_idle();
    end

    // Write to a shared block held by the other cache
    set_dir(4'h3, 3'b010, 2'b11);
    drive_one(1, 1'b1, 4'h3, 4'hA);
    wait_idle();

    // Read of a block modified in the other cache: recall then fetch
    set_dir(4'h5, 3'b011, 2'b10);
    drive_one(0, 1'b0, 4'h5, 4'h0);
    wait_idle();

    // Randomised traffic from both caches
    inv_lat_max = 4; mem_lat_max = 3;
    fork
      drive_port(0, 30);
      drive_port(1, 30);
    join
    wait_idle();

    // Invalidation that is never acknowledged, then Error must persist
    inv_en = 2'b00;
    set_dir(4'h7, 3'b010, 2'b01);
    drive_one(1, 1'b1, 4'h7, 4'h9);
    wait_idle();
    inv_en = 2'b11;
    drive_one(0, 1'b0, 4'h2, 4'h0);
    wait_idle();

    // Reset while waiting on memory, then a normal transaction
    mem_hold = 1'b1;
    set_dir(4'h4, 3'b001, 2'b00);
    drive_one(0, 1'b0, 4'h4, 4'h0);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (mem_read) begin seen = 1'b1; break; end
      end
      if (!seen) hang_flag = 1'b1;
    end
    @(posedge clk); #1;
    do_reset();
    mem_hold = 1'b0;
    drive_one(0, 1'b0, 4'h4, 4'h0);
    wait_idle();

    // Illegal directory encoding is treated as Invalid and flags Error
    set_dir(4'h6, 3'b101, 2'b00);
    drive_one(1, 1'b0, 4'h6, 4'h0);
    wait_idle();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
